// File: rtl/uart_pixel_loader.sv
// uart_pixel_loader: 8N1 UART receiver -> RGB565 word assembler -> FWFT FIFO
// with a valid/ready output towards the LCD controller colour input.
// Optional feature macro: UART_PIXEL_LOADER_RESYNC_EN (timeout that discards a
// stale pending high byte after two idle byte-times).
module uart_pixel_loader #(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 57600,
  parameter int fifo_aw        = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_rx,
  output logic [15:0]        pixel_data,
  output logic               pixel_valid,
  input  logic               pixel_ready,
  output logic [fifo_aw:0]   fifo_count,
  output logic               frame_error,
  output logic               overflow,
  output logic               half_word
);

  localparam int DIV_RAW = clk_freq / (uart_baud_rate * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH   = 1 << fifo_aw;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [fifo_aw:0]   CNT_FULL = (fifo_aw + 1)'(DEPTH);
  localparam logic [fifo_aw:0]   CNT_ONE  = (fifo_aw + 1)'(1);
  localparam logic [fifo_aw-1:0] PTR_ONE  = fifo_aw'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [DIV_W-1:0] div_cnt_q;
  logic             tick;
  logic             rx_s1_q, rx_s2_q;
  state_t           state_q, state_d;
  logic [3:0]       tcnt_q, tcnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_ok, byte_bad;
  logic [7:0]       hi_q;
  logic [15:0]      word_q;
  logic             half_q, push_q, fe_q;
  logic [15:0]      mem [DEPTH];
  logic [fifo_aw-1:0] wr_q, rd_q;
  logic [fifo_aw:0] cnt_q;
  logic             ovf_q;
  logic             pop, full, wr_en;

  assign tick = (div_cnt_q == DIV_LAST);

  // Free-running 16x oversample tick divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt_q <= '0;
    else if (tick) div_cnt_q <= '0;
    else           div_cnt_q <= div_cnt_q + 1'b1;
  end

  // Two-flop synchroniser; idle-high reset value avoids a false start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= uart_rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  // RX FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // RX FSM next state: mid-bit sampling, LSB first, stop-bit validation.
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_ok   = 1'b0;
    byte_bad  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s2_q) begin
          state_d = START;
          tcnt_d  = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tcnt_q == 4'd7) begin
            tcnt_d    = '0;
            bit_cnt_d = '0;
            state_d   = rx_s2_q ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tcnt_q == 4'd15) begin
            tcnt_d    = '0;
            shift_d   = {rx_s2_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = STOP;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tcnt_q == 4'd15) begin
            tcnt_d   = '0;
            state_d  = IDLE;
            byte_ok  = rx_s2_q;
            byte_bad = !rx_s2_q;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_PIXEL_LOADER_RESYNC_EN
  logic [8:0] rs_cnt_q;
  logic       rs_timeout;

  assign rs_timeout = half_q && (state_q == IDLE) && tick && (rs_cnt_q == 9'd319);

  // Idle timeout counter for a stale pending high byte (two byte-times).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              rs_cnt_q <= '0;
    else if (!half_q || state_q != IDLE)  rs_cnt_q <= '0;
    else if (tick)                        rs_cnt_q <= rs_timeout ? 9'd0 : rs_cnt_q + 9'd1;
  end
`endif

  // Byte pairing: high byte first, push of the full word one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      word_q <= '0;
      half_q <= 1'b0;
      push_q <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      push_q <= 1'b0;
      fe_q   <= byte_bad;
      if (byte_bad) begin
        half_q <= 1'b0;
      end else if (byte_ok) begin
        if (half_q) begin
          word_q <= {hi_q, shift_q};
          half_q <= 1'b0;
          push_q <= 1'b1;
        end else begin
          hi_q   <= shift_q;
          half_q <= 1'b1;
        end
      end
`ifdef UART_PIXEL_LOADER_RESYNC_EN
      else if (rs_timeout) begin
        half_q <= 1'b0;
      end
`endif
    end
  end

  assign full  = (cnt_q == CNT_FULL);
  assign pop   = (cnt_q != '0) && pixel_ready;
  assign wr_en = push_q && (!full || pop);

  // FIFO storage; contents are discarded on reset via the pointers/count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q] <= word_q;
  end

  // FIFO pointers, occupancy count and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + PTR_ONE;
      if (pop)   rd_q <= rd_q + PTR_ONE;
      if (wr_en && !pop)      cnt_q <= cnt_q + CNT_ONE;
      else if (pop && !wr_en) cnt_q <= cnt_q - CNT_ONE;
      if (push_q && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign pixel_valid = (cnt_q != '0);
  assign pixel_data  = pixel_valid ? mem[rd_q] : 16'h0000;
  assign fifo_count  = cnt_q;
  assign frame_error = fe_q;
  assign overflow    = ovf_q;
  assign half_word   = half_q;

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Self-checking bench for uart_pixel_loader: queue-based reference model of the
// byte pairing and FIFO, a per-cycle compare process, and literal spot checks.
module tb_uart_pixel_loader;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_rx = 1'b1;
  logic          pixel_ready;
  logic [15:0]   pixel_data;
  logic          pixel_valid;
  logic [AW:0]   fifo_count;
  logic          frame_error;
  logic          overflow;
  logic          half_word;

  uart_pixel_loader #(
    .clk_freq(1600000),
    .uart_baud_rate(100000),
    .fifo_aw(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .uart_rx(uart_rx),
    .pixel_data(pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .fifo_count(fifo_count),
    .frame_error(frame_error),
    .overflow(overflow),
    .half_word(half_word)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [15:0] q[$];
  logic [15:0] popped[$];
  int          pop_cyc[$];
  bit          m_half = 0, m_fe = 0, m_ovf = 0, m_pend = 0;
  logic [7:0]  m_hi = 8'h00;
  logic [15:0] m_word = 16'h0000;

  bit mon_en = 0;
  bit hw_skip = 0;
  int ready_mode = 0;
  int fe_pulses = 0;
  int rise_cyc = -1;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Consumer ready driver: 0 = hold low, 1 = hold high, 2 = random.
  initial begin
    pixel_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       pixel_ready = 1'b0;
        1:       pixel_ready = 1'b1;
        default: pixel_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid", {31'd0, pixel_valid}, {31'd0, (q.size() != 0)});
      chk("count", {29'd0, fifo_count}, q.size());
      if (q.size() != 0) chk("data", {16'd0, pixel_data}, {16'd0, q[0]});
      if (!hw_skip) chk("half", {31'd0, half_word}, {31'd0, m_half});
      chk("ferr", {31'd0, frame_error}, {31'd0, m_fe});
      chk("ovf", {31'd0, overflow}, {31'd0, m_ovf});
      if (frame_error) fe_pulses++;
      if (pixel_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = pixel_valid;
      if (pixel_ready && q.size() != 0) begin
        popped.push_back(q.pop_front());
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Model: effect of a completed stop-bit sample.
  task automatic m_stop(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_fe   = 1;
      m_half = 0;
    end else if (!m_half) begin
      m_hi   = b;
      m_half = 1;
    end else begin
      m_word = {m_hi, b};
      m_half = 0;
      m_pend = 1;
    end
  endtask

  // Model: the cycle after the stop sample (push into the FIFO).
  task automatic m_push();
    m_fe = 0;
    if (m_pend) begin
      m_pend = 0;
      if (q.size() < DEPTH) q.push_back(m_word);
      else                  m_ovf = 1;
    end
  endtask

  // Drive one 8N1 frame (16 clocks/bit). ncyc < 160 aborts mid-frame.
  task automatic send_frame(input logic [7:0] b, input bit ok, input int ncyc,
                            input bit ready_at, output int c0);
    logic [9:0] bits;
    bits = {ok, b, 1'b0};
    c0 = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) c0 = cyc;
      if (i < 144)      uart_rx = bits[i / 16];
      else if (i < 153) uart_rx = ok;
      else              uart_rx = 1'b1;
      if (i == 155) begin
        m_stop(b, ok);
        if (ready_at) ready_mode = 1;
      end
      if (i == 156) m_push();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int c;
    send_frame(b, 1'b1, 160, 1'b0, c);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    uart_rx = 1'b1;
    q.delete();
    m_half = 0; m_fe = 0; m_ovf = 0; m_pend = 0;
    hw_skip = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    ready_mode = 1;
    repeat (DEPTH + 2) @(negedge clk);
    ready_mode = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int c;
    logic [7:0] rb;
    bit rok;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, pixel_valid}, 32'd0);
    chk("rst_data", {16'd0, pixel_data}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_ferr", {31'd0, frame_error}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_half", {31'd0, half_word}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1;

    // Single word 0xF81F, valid latency from second stop sample
    ready_mode = 0;
    popped.delete();
    send_byte(8'hF8);
    @(negedge clk);
    chk("s1_half_mid", {31'd0, half_word}, 32'd1);
    rise_cyc = -1;
    send_frame(8'h1F, 1'b1, 160, 1'b0, c);
    @(negedge clk);
    chk("s1_data", {16'd0, pixel_data}, 32'h0000F81F);
    chk("s1_count", {29'd0, fifo_count}, 32'd1);
    chk("s1_half", {31'd0, half_word}, 32'd0);
    chk("s1_rise", rise_cyc, c + 156);
    drain();
    chk("s1_npop", popped.size(), 32'd1);
    if (popped.size() > 0) chk("s1_pop", {16'd0, popped[0]}, 32'h0000F81F);

    // Five words into a four-deep FIFO, then a back-to-back drain
    popped.delete();
    pop_cyc.delete();
    for (int w = 1; w <= 5; w++) begin
      send_byte(8'h00);
      send_byte(8'(w));
    end
    @(negedge clk);
    chk("s2_count", {29'd0, fifo_count}, 32'd4);
    chk("s2_ovf", {31'd0, overflow}, 32'd1);
    chk("s2_head", {16'd0, pixel_data}, 32'h00000001);
    ready_mode = 1;
    repeat (6) @(negedge clk);
    chk("s2_valid_end", {31'd0, pixel_valid}, 32'd0);
    chk("s2_npop", popped.size(), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < popped.size()) chk("s2_pop", {16'd0, popped[k]}, k + 1);
    if (pop_cyc.size() == 4) chk("s2_consec", pop_cyc[3] - pop_cyc[0], 32'd3);
    ready_mode = 0;

    // Framing error discards the pending high byte
    do_reset();
    fe_pulses = 0;
    send_byte(8'h12);
    send_frame(8'h99, 1'b0, 160, 1'b0, c);
    @(negedge clk);
    chk("s3_fe_pulses", fe_pulses, 32'd1);
    chk("s3_half", {31'd0, half_word}, 32'd0);
    chk("s3_count", {29'd0, fifo_count}, 32'd0);
    send_byte(8'h34);
    send_byte(8'h56);
    @(negedge clk);
    chk("s3_data", {16'd0, pixel_data}, 32'h00003456);
    drain();

    // Short low glitch: no byte, no error
    fe_pulses = 0;
    @(posedge clk); #1; uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1; uart_rx = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("s4_fe", fe_pulses, 32'd0);
    chk("s4_half", {31'd0, half_word}, 32'd0);
    chk("s4_count", {29'd0, fifo_count}, 32'd0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    popped.delete();
    for (int w = 1; w <= 4; w++) begin
      send_byte(8'h00);
      send_byte(8'(w * 17));
    end
    send_byte(8'h00);
    send_frame(8'hAA, 1'b1, 160, 1'b1, c);
    repeat (8) @(negedge clk);
    ready_mode = 0;
    chk("s5_ovf", {31'd0, overflow}, 32'd0);
    chk("s5_npop", popped.size(), 32'd5);
    if (popped.size() == 5) chk("s5_aa", {16'd0, popped[4]}, 32'h000000AA);

    // Randomised traffic with random consumer stalls and occasional bad stop bits
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      rb  = 8'($urandom);
      rok = ($urandom_range(0, 7) != 0);
      send_frame(rb, rok, 160, 1'b0, c);
    end
    drain();

    // Reset mid-word and mid-byte discards partial state
    send_byte(8'hEE);
    send_frame(8'h5A, 1'b1, 80, 1'b0, c);
    do_reset();
    @(negedge clk);
    chk("s7_half", {31'd0, half_word}, 32'd0);
    send_byte(8'h12);
    send_byte(8'h34);
    @(negedge clk);
    chk("s7_data", {16'd0, pixel_data}, 32'h00001234);

    // Pending high byte across a long idle gap
    do_reset();
    ready_mode = 0;
    send_byte(8'h77);
    hw_skip = 1;
    repeat (340) @(posedge clk);
    #1;
`ifdef UART_PIXEL_LOADER_RESYNC_EN
    m_half = 0;
`endif
    hw_skip = 0;
    @(negedge clk);
`ifdef UART_PIXEL_LOADER_RESYNC_EN
    chk("s8_half_gap", {31'd0, half_word}, 32'd0);
`else
    chk("s8_half_gap", {31'd0, half_word}, 32'd1);
`endif
    send_byte(8'hAB);
    send_byte(8'hCD);
    @(negedge clk);
`ifdef UART_PIXEL_LOADER_RESYNC_EN
    chk("s8_word", {16'd0, pixel_data}, 32'h0000ABCD);
`else
    chk("s8_word", {16'd0, pixel_data}, 32'h000077AB);
`endif
    drain();

    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
